// File: rtl/spi_ctrl_pkg.sv
// Shared types and defaults for the SPI transfer control path.
package spi_ctrl_pkg;

    typedef enum logic [1:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT,
        S_DONE
    } seq_state_t;

    localparam logic [7:0] DEF_DUMMY_BYTE = 8'hFF;
    localparam int         DEF_FIFO_DEPTH = 8;

endpackage

// File: rtl/spi_sync_fifo.sv
// Single-clock FIFO with first-word-fall-through read data and synchronous flush.
module spi_sync_fifo #(
    parameter  int DEPTH = 8,
    parameter  int WIDTH = 8,
    localparam int AW    = $clog2(DEPTH),
    localparam int LW    = AW + 1
) (
    input  logic             clk_i,
    input  logic             reset_n_i,
    input  logic             flush_i,
    input  logic             push_i,
    input  logic [WIDTH-1:0] wdata_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] rdata_o,
    output logic             full_o,
    output logic             empty_o,
    output logic [LW-1:0]    level_o
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [LW-1:0]    level;
    logic             do_push;
    logic             do_pop;

    assign full_o  = (level == LW'(DEPTH));
    assign empty_o = (level == '0);
    assign level_o = level;

    // A full FIFO refuses a push even when a pop frees a slot that same cycle.
    assign do_push = push_i && !full_o && !flush_i;
    assign do_pop  = pop_i && !empty_o && !flush_i;

    // Head is forced to zero when empty so stale storage never leaks out.
    assign rdata_o = empty_o ? '0 : mem[rd_ptr];

    always_ff @(posedge clk_i) begin
        if (do_push) begin
            mem[wr_ptr] <= wdata_i;
        end
    end

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else if (flush_i) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({do_push, do_pop})
                2'b10:   level <= level + LW'(1);
                2'b01:   level <= level - LW'(1);
                default: level <= level;
            endcase
        end
    end

endmodule

// File: rtl/spi_xfer_sequencer.sv
// Multi-byte transfer sequencer feeding spi_protocol_engine one byte at a time.
//   state   | meaning
//   S_IDLE  | waiting for start; flush allowed
//   S_ISSUE | offering next byte to engine (stalls on TX empty / RX full)
//   S_WAIT  | one byte in flight, waiting for engine rx_valid
//   S_DONE  | one-cycle completion pulse
module spi_xfer_sequencer
    import spi_ctrl_pkg::*;
#(
    parameter  int         FIFO_DEPTH = DEF_FIFO_DEPTH,
    parameter  logic [7:0] DUMMY_BYTE = DEF_DUMMY_BYTE,
    localparam int         LVL_W      = $clog2(FIFO_DEPTH) + 1
) (
    input  logic             clk_i,
    input  logic             reset_n_i,
    input  logic             start_i,
    input  logic [15:0]      len_i,
    input  logic             rx_only_i,
    input  logic             abort_i,
    input  logic             flush_i,
    input  logic [7:0]       tx_wdata_i,
    input  logic             tx_wvalid_i,
    output logic             tx_wready_o,
    output logic [7:0]       rx_rdata_o,
    output logic             rx_rvalid_o,
    input  logic             rx_rready_i,
    output logic             eng_enable_o,
    output logic [7:0]       eng_tx_data_o,
    output logic             eng_tx_valid_o,
    input  logic             eng_tx_ready_i,
    input  logic [7:0]       eng_rx_data_i,
    input  logic             eng_rx_valid_i,
    output logic             busy_o,
    output logic             done_o,
    output logic             aborted_o,
    output logic [15:0]      bytes_left_o,
    output logic [LVL_W-1:0] tx_level_o,
    output logic [LVL_W-1:0] rx_level_o
);

    seq_state_t  state;
    logic [15:0] bytes_left;
    logic        rx_only;
    logic        abort_pend;
    logic        aborted;

    logic        tx_full, tx_empty, rx_full, rx_empty;
    logic [7:0]  tx_head;
    logic        handshake;
    logic        flush_ok;
    logic        rx_push;

    assign flush_ok  = flush_i && (state == S_IDLE);
    assign rx_push   = (state == S_WAIT) && eng_rx_valid_i;
    assign handshake = eng_tx_valid_o && eng_tx_ready_i;

    // Issue is gated on RX space so the RX FIFO can never overflow.
    assign eng_tx_valid_o = (state == S_ISSUE) && (rx_only || !tx_empty) && !rx_full;
    assign eng_tx_data_o  = rx_only ? DUMMY_BYTE : tx_head;

    assign busy_o       = (state != S_IDLE);
    assign eng_enable_o = (state != S_IDLE);
    assign done_o       = (state == S_DONE);
    assign aborted_o    = aborted;
    assign bytes_left_o = bytes_left;
    assign tx_wready_o  = !tx_full;
    assign rx_rvalid_o  = !rx_empty;

    spi_sync_fifo #(.DEPTH(FIFO_DEPTH), .WIDTH(8)) u_tx_fifo (
        .clk_i     (clk_i),
        .reset_n_i (reset_n_i),
        .flush_i   (flush_ok),
        .push_i    (tx_wvalid_i),
        .wdata_i   (tx_wdata_i),
        .pop_i     (handshake && !rx_only),
        .rdata_o   (tx_head),
        .full_o    (tx_full),
        .empty_o   (tx_empty),
        .level_o   (tx_level_o)
    );

    spi_sync_fifo #(.DEPTH(FIFO_DEPTH), .WIDTH(8)) u_rx_fifo (
        .clk_i     (clk_i),
        .reset_n_i (reset_n_i),
        .flush_i   (flush_ok),
        .push_i    (rx_push),
        .wdata_i   (eng_rx_data_i),
        .pop_i     (rx_rready_i),
        .rdata_o   (rx_rdata_o),
        .full_o    (rx_full),
        .empty_o   (rx_empty),
        .level_o   (rx_level_o)
    );

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state      <= S_IDLE;
            bytes_left <= '0;
            rx_only    <= 1'b0;
            abort_pend <= 1'b0;
            aborted    <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start_i) begin
                        bytes_left <= len_i;
                        rx_only    <= rx_only_i;
                        abort_pend <= 1'b0;
                        aborted    <= 1'b0;
                        state      <= (len_i == 16'd0) ? S_DONE : S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    // An abort coinciding with a handshake lets that byte finish first.
                    if (handshake) begin
                        state <= S_WAIT;
                        if (abort_i) begin
                            abort_pend <= 1'b1;
                        end
                    end else if (abort_i) begin
                        state   <= S_DONE;
                        aborted <= 1'b1;
                    end
                end
                S_WAIT: begin
                    if (eng_rx_valid_i) begin
                        bytes_left <= bytes_left - 16'd1;
                        if (bytes_left == 16'd1 || abort_pend || abort_i) begin
                            state   <= S_DONE;
                            aborted <= abort_pend || abort_i;
                        end else begin
                            state <= S_ISSUE;
                        end
                    end else if (abort_i) begin
                        abort_pend <= 1'b1;
                    end
                end
                S_DONE: begin
                    state <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: doc/spi_xfer_sequencer.md
Name: spi_xfer_sequencer

Overview:
Multi-byte transfer sequencer that sits directly upstream of spi_protocol_engine. It buffers host TX bytes in a TX FIFO and issues them one at a time over the engine's tx_valid/tx_ready handshake. Each returned byte (the engine's rx_valid pulse) is pushed into an RX FIFO for the host. It counts bytes, supports RX-only (dummy-byte) transfers, supports abort, and reports completion.

Parameters:
FIFO_DEPTH, 8, entries per FIFO; power of two, >=2
DUMMY_BYTE, 8'hFF, byte sent in RX-only mode
LVL_W, $clog2(FIFO_DEPTH)+1, level field width (derived localparam)

Ports:
clk_i  input  1  system clock
reset_n_i  input  1  asynchronous, active-low reset
start_i  input  1  start transfer (pulse); ignored unless idle
len_i  input  16  byte count, sampled on accepted start
rx_only_i  input  1  send DUMMY_BYTE, do not pop TX FIFO; sampled on start
abort_i  input  1  stop after in-flight byte (pulse)
flush_i  input  1  clear both FIFOs; honoured only when idle
tx_wdata_i  input  8  host TX byte
tx_wvalid_i  input  1  host TX push request
tx_wready_o  output  1  TX FIFO not full
rx_rdata_o  output  8  RX FIFO head (first-word-fall-through)
rx_rvalid_o  output  1  RX FIFO not empty
rx_rready_i  input  1  host RX pop
eng_enable_o  output  1  to engine enable_i
eng_tx_data_o  output  8  to engine tx_data_i
eng_tx_valid_o  output  1  to engine tx_valid_i
eng_tx_ready_i  input  1  from engine tx_ready_o
eng_rx_data_i  input  8  from engine rx_data_o
eng_rx_valid_i  input  1  from engine rx_valid_o
busy_o  output  1  sequencer not idle
done_o  output  1  1-cycle completion pulse
aborted_o  output  1  last transfer ended by abort; held until next start
bytes_left_o  output  16  remaining byte count
tx_level_o  output  LVL_W  TX FIFO occupancy
rx_level_o  output  LVL_W  RX FIFO occupancy

Behaviour:
- Reset values: all state cleared; FIFOs empty. tx_wready_o=1; rx_rvalid_o=0; rx_rdata_o=0; all other outputs 0.
- FSM states: S_IDLE, S_ISSUE, S_WAIT, S_DONE.
- S_IDLE + start_i: latch len_i into bytes_left and rx_only_i into the mode; clear aborted_o.
  - len_i==0 -> S_DONE.
  - otherwise -> S_ISSUE.
- S_ISSUE: eng_tx_valid_o=1 iff (rx_only or TX FIFO non-empty) and rx_level < FIFO_DEPTH.
  - eng_tx_data_o = rx_only ? DUMMY_BYTE : TX FIFO head.
  - Handshake occurs when eng_tx_valid_o && eng_tx_ready_i. On handshake: pop TX FIFO (unless rx_only) and go to S_WAIT.
  - If the stall condition holds (TX empty or RX full), hold valid low and stay in S_ISSUE indefinitely.
- S_WAIT: eng_tx_valid_o=0. On eng_rx_valid_i: push eng_rx_data_i into RX FIFO and decrement bytes_left.
  - bytes_left==1 before the decrement, or abort pending -> S_DONE.
  - otherwise -> S_ISSUE.
- S_DONE: done_o=1 for exactly one cycle -> S_IDLE.
- eng_enable_o = busy_o = (state != S_IDLE). Exactly one byte is in flight at any time.
- Abort:
  - abort_i in S_ISSUE with no handshake that cycle -> S_DONE next cycle, aborted_o=1.
  - abort_i in S_WAIT: set abort-pending; the in-flight byte still completes and is pushed; then S_DONE with aborted_o=1.
  - abort_i while idle: ignored.
- Abort and start_i in the same cycle while idle: start wins.
- start_i while busy: ignored.
- flush_i while busy: ignored. flush_i while idle: both FIFOs emptied next cycle. Same-cycle push or pop with flush is discarded.
- TX FIFO: push when tx_wvalid_i && tx_wready_o. When full, a push is refused even if a pop occurs in the same cycle. Simultaneous push and pop when not full leaves the level unchanged.
- RX FIFO: pop when rx_rvalid_o && rx_rready_i. Overflow is impossible by construction, because issue is gated on rx_level < FIFO_DEPTH.
- Pointers are log2(FIFO_DEPTH) bits and wrap naturally. Levels saturate by construction at 0..FIFO_DEPTH.
- Latency: from start_i (cycle N), eng_tx_valid_o can first assert at N+1. Between eng_rx_valid_i and the next eng_tx_valid_o there is a 1-cycle gap, which matches the engine's STOP->IDLE return.
- Reset mid-transfer: everything is cleared immediately and no done_o is emitted.

Decomposition:
- Package spi_ctrl_pkg holds:
  - the seq_state_t enum (S_IDLE, S_ISSUE, S_WAIT, S_DONE);
  - the default DUMMY_BYTE;
  - the default FIFO depth constant.
- Sub-module spi_sync_fifo (parameter DEPTH, WIDTH=8; push/pop, full/empty/level, FWFT data, synchronous flush) is instantiated twice, for TX and RX.

Test Plan:
- Push 8'hA5, 8'h3C; start len=2 -> engine sees A5 then 3C. rx_level reaches 2. done_o pulses once. bytes_left_o=0. aborted_o=0.
- rx_only=1, len=3, TX FIFO empty -> eng_tx_data_o=8'hFF on 3 handshakes. TX level stays 0. RX receives 3 bytes.
- Start len=4 with only 1 TX byte queued -> after byte 1, eng_tx_valid_o stays low. Push 3 more bytes -> transfer resumes and completes with 4 RX bytes.
- FIFO_DEPTH=8, rx_only, len=10, host never pops -> stall with rx_level=8 and bytes_left_o=2. Pop 2 -> remaining 2 bytes complete.
- Start len=5, abort_i asserted in S_WAIT of byte 2 -> byte 2 completes. done_o asserts. aborted_o=1. bytes_left_o=3. rx_level=2.
- Start len=0 -> done_o at N+1 with no engine handshake. Separately, assert reset_n_i low mid-byte -> all outputs return to reset values and no done_o is emitted.
